// File: rtl/motor_pkg.sv
// Shared types and default widths for the step/direction motor driver blocks.
package motor_pkg;

    localparam int unsigned PERIOD_W_DEF = 16;
    localparam int unsigned COUNT_W_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } stepState_t;

endpackage

// File: rtl/step_pulse_generator_phase_timer.sv
// Down-counter shared by the HIGH and LOW phases; expire flags the last cycle of a phase.
module phase_timer
    import motor_pkg::*;
#(
    parameter int unsigned WIDTH = PERIOD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so an unloaded timer can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/step_pulse_generator.sv
// Burst step-pulse generator: emits step_count pulses of configurable period and
// high time with a latched direction, abortable at any point.
module step_pulse_generator
    import motor_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] high_time,
    input  logic [COUNT_W-1:0]  step_count,
    input  logic                dir_in,
    input  logic                abort,
    output logic                step_out,
    output logic                dir_out,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  steps_left
);

    stepState_t          state;
    logic [PERIOD_W-1:0] highLen;
    logic [PERIOD_W-1:0] lowLen;
    logic [PERIOD_W-1:0] effPeriod_c;
    logic [PERIOD_W-1:0] effHigh_c;
    logic [PERIOD_W-1:0] timerValue_c;
    logic                timerLoad_c;
    logic                timerExpire;
    logic                accept_c;

    assign accept_c = (state == IDLE) && start && !abort;

    // Period floor of 2 guarantees both phases get at least one cycle.
    always_comb begin
        effPeriod_c = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
        if (high_time == '0) begin
            effHigh_c = PERIOD_W'(1);
        end else if (high_time >= effPeriod_c) begin
            effHigh_c = effPeriod_c - PERIOD_W'(1);
        end else begin
            effHigh_c = high_time;
        end
    end

    // Timer reload happens on the same edge as the phase transition it times.
    always_comb begin
        timerLoad_c  = 1'b0;
        timerValue_c = '0;
        if (state != IDLE && abort) begin
            timerLoad_c = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept_c && step_count != '0) begin
                        timerLoad_c  = 1'b1;
                        timerValue_c = effHigh_c;
                    end
                end
                HIGH: begin
                    if (timerExpire) begin
                        timerLoad_c  = 1'b1;
                        timerValue_c = lowLen;
                    end
                end
                LOW: begin
                    if (timerExpire) begin
                        timerLoad_c  = 1'b1;
                        timerValue_c = (steps_left != '0) ? highLen : '0;
                    end
                end
                DONE: begin
                    timerLoad_c = 1'b0;
                end
                default: begin
                    timerLoad_c = 1'b1;
                end
            endcase
        end
    end

    phase_timer #(
        .WIDTH (PERIOD_W)
    ) uPhaseTimer (
        .clk    (clk),
        .rst    (rst),
        .load   (timerLoad_c),
        .value  (timerValue_c),
        .expire (timerExpire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_left <= '0;
            highLen    <= '0;
            lowLen     <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state      <= IDLE;
                step_out   <= 1'b0;
                busy       <= 1'b0;
                steps_left <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept_c) begin
                            dir_out <= dir_in;
                            highLen <= effHigh_c;
                            lowLen  <= effPeriod_c - effHigh_c;
                            busy    <= 1'b1;
                            if (step_count == '0) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                steps_left <= '0;
                            end else begin
                                state      <= HIGH;
                                step_out   <= 1'b1;
                                steps_left <= step_count - COUNT_W'(1);
                            end
                        end
                    end
                    HIGH: begin
                        if (timerExpire) begin
                            state    <= LOW;
                            step_out <= 1'b0;
                        end
                    end
                    LOW: begin
                        if (timerExpire) begin
                            if (steps_left == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= HIGH;
                                step_out   <= 1'b1;
                                steps_left <= steps_left - COUNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        step_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Randomised scoreboard bench for step_pulse_generator: the driver predicts pulse and done
// events from the burst parameters, the monitor reconstructs them from the DUT outputs.
module tb_step_pulse_generator;

    localparam int unsigned PW = 16;
    localparam int unsigned CW = 12;

    typedef struct {
        bit isDone;
        int cyc;
        int len;
        bit dir;
        int left;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dir_in = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] period = '0;
    logic [PW-1:0] high_time = '0;
    logic [CW-1:0] step_count = '0;
    logic          step_out;
    logic          dir_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_left;

    ev_t expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    step_pulse_generator #(
        .PERIOD_W (PW),
        .COUNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .period     (period),
        .high_time  (high_time),
        .step_count (step_count),
        .dir_in     (dir_in),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: rebuild pulse/done events from the output waveform and compare in order.
    int  riseCyc = 0;
    int  riseLeft = 0;
    bit  riseDir = 1'b0;
    bit  prevStep = 1'b0;
    ev_t monEv;

    task automatic emit(input ev_t got);
        ev_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got isDone=%0d at cycle %0d, expected no event", got.isDone, got.cyc);
        end else begin
            e = expQ.pop_front();
            check("event_kind", 32'(got.isDone), 32'(e.isDone));
            check("event_cycle", got.cyc, e.cyc);
            if (!e.isDone) begin
                check("pulse_len", got.len, e.len);
                check("pulse_dir", 32'(got.dir), 32'(e.dir));
                check("pulse_steps_left", got.left, e.left);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prevStep = 1'b0;
        end else begin
            if (step_out && !prevStep) begin
                riseCyc  = cyc;
                riseLeft = int'(steps_left);
                riseDir  = dir_out;
            end
            if (!step_out && prevStep) begin
                monEv = '{isDone: 1'b0, cyc: riseCyc, len: cyc - riseCyc, dir: riseDir, left: riseLeft};
                emit(monEv);
            end
            if (done) begin
                check("done_step_low", 32'(step_out), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
                monEv = '{isDone: 1'b1, cyc: cyc, len: 0, dir: 1'b0, left: 0};
                emit(monEv);
            end
            prevStep = step_out;
        end
    end

    // Driver + reference model: one burst, optional abort offset (-1 = none), optional mid-burst start.
    task automatic runBurst(input int per, input int hi, input int cnt, input bit dir,
                            input int abortOff, input bit midStart);
        int  pe;
        int  he;
        int  e;
        int  d;
        int  a;
        int  r;
        int  f;
        int  n;
        bit  aborting;
        ev_t x;
        pe = (per < 2) ? 2 : per;
        he = (hi < 1) ? 1 : hi;
        if (he > pe - 1) he = pe - 1;
        aborting = (abortOff >= 0) && (cnt > 0);
        @(negedge clk);
        e = cyc + 1;
        d = e + cnt * pe;
        a = e + abortOff;
        if (aborting && a > d - 1) a = d - 1;
        for (int k = 0; k < cnt; k++) begin
            r = e + k * pe;
            if (aborting && r > a) break;
            f = r + he;
            if (aborting && f > a + 1) f = a + 1;
            x = '{isDone: 1'b0, cyc: r, len: f - r, dir: dir, left: cnt - 1 - k};
            expQ.push_back(x);
        end
        if (!aborting) begin
            x = '{isDone: 1'b1, cyc: d, len: 0, dir: 1'b0, left: 0};
            expQ.push_back(x);
        end
        period     = PW'(per);
        high_time  = PW'(hi);
        step_count = CW'(cnt);
        dir_in     = dir;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (midStart && d > e + 1 && (!aborting || a > e + 1)) begin
            @(negedge clk);
            start      = 1'b1;
            dir_in     = ~dir;
            period     = PW'($urandom_range(0, 30));
            high_time  = PW'($urandom_range(0, 30));
            step_count = CW'($urandom_range(1, 9));
            @(negedge clk);
            start = 1'b0;
        end
        if (aborting) begin
            while (cyc < a) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_step_out", 32'(step_out), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_steps_left", 32'(steps_left), 32'd0);
            check("abort_no_done", 32'(done), 32'd0);
        end else begin
            n = 0;
            while (busy && n < 4000) begin
                @(negedge clk);
                n++;
            end
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
            end else begin
                check("idle_cycle", cyc, d + 1);
                check("idle_steps_left", 32'(steps_left), 32'd0);
                check("idle_step_out", 32'(step_out), 32'd0);
            end
        end
    endtask

    initial begin
        int per;
        int hi;
        int cnt;
        int ab;
        int pe;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_step_out", 32'(step_out), 32'd0);
        check("reset_dir_out", 32'(dir_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_steps_left", 32'(steps_left), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        runBurst(10, 3, 4, 1'b1, -1, 1'b0);
        runBurst(7, 2, 0, 1'b0, -1, 1'b0);
        runBurst(1, 0, 3, 1'b1, -1, 1'b0);
        runBurst(8, 20, 2, 1'b0, -1, 1'b0);
        runBurst(10, 3, 5, 1'b1, 11, 1'b0);
        runBurst(10, 3, 4, 1'b0, -1, 1'b1);

        // Stop with start and abort together: abort must win.
        @(negedge clk);
        period = PW'(6); high_time = PW'(2); step_count = CW'(3); dir_in = 1'b1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start_busy", 32'(busy), 32'd0);
        check("abort_beats_start_step", 32'(step_out), 32'd0);

        // Asynchronous reset in the middle of a HIGH phase.
        @(negedge clk);
        period = PW'(10); high_time = PW'(3); step_count = CW'(4); dir_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_step_out", 32'(step_out), 32'd0);
        check("async_rst_dir_out", 32'(dir_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_steps_left", 32'(steps_left), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
            check("post_rst_idle", 32'(busy), 32'd0);
        end
        runBurst(10, 3, 4, 1'b0, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            per = int'($urandom_range(0, 12));
            hi  = int'($urandom_range(0, 15));
            cnt = int'($urandom_range(0, 5));
            pe  = (per < 2) ? 2 : per;
            ab  = -1;
            if (cnt > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(0, cnt * pe - 1));
            runBurst(per, hi, cnt, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_pulse_generator.md
STEP_PULSE_GENERATOR -- requirements
Module: step_pulse_generator

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of period/high-time fields.
REQ-002 SHALL have parameter COUNT_W, default 12, width of step-count fields.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request a burst; sampled only in IDLE.
REQ-007 period  input  PERIOD_W  cycles per step pulse, latched on accept.
REQ-008 high_time  input  PERIOD_W  cycles step_out is high per pulse, latched on accept.
REQ-009 step_count  input  COUNT_W  number of pulses in the burst, latched on accept.
REQ-010 dir_in  input  1  motor direction, latched on accept.
REQ-011 abort  input  1  terminate burst immediately.
REQ-012 step_out  output  1  registered step pulse train.
REQ-013 dir_out  output  1  registered direction, stable while busy.
REQ-014 busy  output  1  high in HIGH, LOW and DONE states.
REQ-015 done  output  1  single-cycle pulse on normal burst completion.
REQ-016 steps_left  output  COUNT_W  pulses not yet started.

Function
REQ-017 FSM states SHALL be IDLE, HIGH, LOW, DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL accept; latch all fields; go HIGH, or DONE if step_count=0.
REQ-019 Effective period Pe SHALL be max(period,2); effective high He SHALL be clamp(high_time,1,Pe-1).
REQ-020 step_out SHALL rise the cycle after accept (1-cycle latency) and stay high exactly He cycles.
REQ-021 LOW SHALL hold step_out low exactly Pe-He cycles; pulse edges SHALL be Pe cycles apart.
REQ-022 steps_left SHALL load step_count on accept and decrement by 1 on entry to each HIGH.
REQ-023 LOW expiry with steps_left=0 SHALL go DONE; otherwise HIGH.
REQ-024 DONE SHALL last one cycle with done=1, step_out=0, then IDLE.
REQ-025 start while not IDLE SHALL be ignored; latched fields SHALL not change mid-burst.
REQ-026 abort in any non-IDLE state SHALL go IDLE at the next edge: step_out=0, steps_left=0, done not pulsed.
REQ-027 abort and start in the same IDLE cycle: abort SHALL win, no accept.
REQ-028 dir_out SHALL update only on accept and hold until the next accept.
REQ-029 A single down-counter of PERIOD_W bits SHALL time both phases; no wrap-around is permitted.

Reset
REQ-030 rst=1 SHALL force IDLE, step_out=0, dir_out=0, busy=0, done=0, steps_left=0, counter=0, asynchronously.
REQ-031 Reset mid-burst SHALL discard the burst; no done pulse after release.

Structure
REQ-032 State enum and default widths SHALL live in shared package motor_pkg.
REQ-033 Phase timer SHALL be a sub-module phase_timer (load, value, expire); the rest is one FSM.

Verification
REQ-034 period=10, high_time=3, step_count=4 -> 4 pulses, high 3/low 7, rising edges 10 cycles apart, done once 1 cycle after last LOW.
REQ-035 step_count=0 -> no step_out activity, done pulses 1 cycle after accept, busy 1 cycle.
REQ-036 period=1, high_time=0 -> Pe=2, He=1, 50% duty; high_time=20 with period=8 -> He=7.
REQ-037 abort during pulse 2 of 5 -> step_out low next cycle, IDLE, steps_left=0, no done.
REQ-038 start pulsed mid-burst with new dir_in -> ignored, dir_out and timing unchanged.
REQ-039 rst asserted mid-HIGH -> all outputs zero immediately without clock edge; fresh start afterward behaves per REQ-034.
